pid_update_scheduler: RTL
=========================

Name: pid_update_scheduler

Overview:
Sequences one BLDC control update per sample period: ADC sample, then PID compute, then PWM duty load. A programmable prescaler on the system clock generates the sample tick. Watchdogs guard each handshake, and sticky flags report overrun and timeout. Sits between the system clock domain, the ADC/speed front end, the PID datapath and the PWM generator.

Parameters:
DIV_W, 16, width of the sample-period register and prescaler counter
TO_W, 8, width of the watchdog counter
TIMEOUT, 200, maximum cycles spent in SAMPLE or COMPUTE before abort (1..2^TO_W-1)

Ports:
clk  in  1  system clock, all logic on rising edge
rst  in  1  synchronous reset, active-high
en  in  1  scheduler enable
period  in  DIV_W  sample period minus 1, in clk cycles
adc_done  in  1  ADC result valid (pulse or level)
pid_done  in  1  PID output valid (pulse or level)
clr_flags  in  1  clears overrun and timeout
adc_start  out  1  one-cycle ADC conversion request
pid_start  out  1  one-cycle PID compute request
pwm_load  out  1  one-cycle PWM duty load strobe
busy  out  1  high while state != IDLE
overrun  out  1  sticky: tick arrived while busy
timeout  out  1  sticky: handshake watchdog expired
upd_cnt  out  8  completed updates, wraps 255->0

Behaviour:
- Reset: state IDLE, cnt=0, period_q=0, wd=0. All outputs 0, including upd_cnt and flags.
- Prescaler, en=0:
  - cnt<=0, period_q<=period, no tick.
- Prescaler, en=1:
  - tick = (cnt==period_q), combinational/internal.
  - On tick: cnt<=0 and period_q<=period. Otherwise cnt<=cnt+1.
  - Result: tick every period_q+1 cycles. The first tick occurs in the cycle after the period-th rising edge with en=1.
  - Changes to period take effect only at a tick or while disabled. period=0 gives a tick every cycle.
- FSM states: IDLE, SAMPLE, COMPUTE, UPDATE. All outputs are registered.
- IDLE:
  - On tick: go to SAMPLE, with adc_start=1 in the first SAMPLE cycle only. wd<=0.
  - adc_done and pid_done are ignored.
- SAMPLE:
  - adc_done is accepted in any SAMPLE cycle, including the adc_start cycle.
  - On adc_done: go to COMPUTE, with pid_start=1 in the first COMPUTE cycle only. wd<=0.
  - pid_done is ignored.
- COMPUTE:
  - On pid_done: go to UPDATE.
  - adc_done is ignored.
- UPDATE:
  - Lasts exactly one cycle with pwm_load=1. upd_cnt<=upd_cnt+1 (mod 256). Then go to IDLE.
  - A tick in the UPDATE cycle counts as overrun.
- Watchdog:
  - In SAMPLE and COMPUTE, wd increments each cycle without the awaited done.
  - If wd==TIMEOUT-1 and done is absent: timeout<=1, go to IDLE, no pwm_load, upd_cnt unchanged.
  - Each state therefore lasts at most TIMEOUT cycles.
  - A done arriving in the expiry cycle wins over the timeout.
- Overrun:
  - A tick while state!=IDLE sets overrun<=1. The tick is dropped; no queuing.
- clr_flags:
  - Clears overrun and timeout. If a set and a clear occur in the same cycle, the set wins.
- busy: combinational, state!=IDLE.
- en deasserted mid-sequence: the current sequence runs to completion or timeout. No further ticks are generated.
- rst asserted mid-sequence: immediate return to reset values on the next edge. Any start/load pulse in flight is dropped.

Test Plan:
- Reset, then en=1, period=9, done responders with 2-cycle latency:
  - adc_start every 10 cycles; pid_start 3 cycles after adc_start; pwm_load 3 cycles after pid_start.
  - upd_cnt increments by 1 per pwm_load; busy high between adc_start and pwm_load inclusive.
- adc_done never asserted, TIMEOUT=200:
  - timeout=1 exactly 200 cycles after adc_start; FSM returns to IDLE; no pid_start or pwm_load.
  - clr_flags=1 for one cycle clears timeout.
- period=3, pid_done delayed 10 cycles:
  - overrun=1 at the first tick seen while busy; subsequent ticks are dropped (no extra adc_start).
  - Exactly one pwm_load per completed sequence.
- period changed from 9 to 4 mid-period:
  - The current interval stays 10 cycles; following intervals are 5 cycles.
- en dropped in COMPUTE:
  - Sequence completes with one pwm_load; no adc_start afterwards.
  - en re-raised: first tick period+1 cycles later.
- adc_done asserted in the same cycle as adc_start:
  - COMPUTE entered next cycle.
- rst pulsed in COMPUTE:
  - Next cycle all outputs 0 and state IDLE; no pwm_load follows.
- 256 completed updates:
  - upd_cnt wraps to 0.

Source files
------------

// File: rtl/pid_update_scheduler.sv
// pid_update_scheduler
// Runs one BLDC control update per sample period: ADC sample, PID compute,
// then PWM duty load. A programmable prescaler produces the sample tick, a
// watchdog bounds the SAMPLE and COMPUTE handshakes, and sticky flags report
// overrun (tick while busy) and timeout (handshake never completed).
//
// Ports:
//   clk        system clock, everything on the rising edge
//   rst        synchronous reset, active-high
//   en         scheduler enable (gates tick generation only)
//   period     sample period minus 1, in clk cycles
//   adc_done   ADC result valid (pulse or level)
//   pid_done   PID output valid (pulse or level)
//   clr_flags  clears overrun and timeout (a same-cycle set wins)
//   adc_start  one-cycle ADC conversion request
//   pid_start  one-cycle PID compute request
//   pwm_load   one-cycle PWM duty load strobe
//   busy       high while the sequencer is not idle
//   overrun    sticky: tick arrived while busy
//   timeout    sticky: handshake watchdog expired
//   upd_cnt    completed updates, wraps 255 -> 0
module pid_update_scheduler #(
  parameter int DIV_W   = 16,
  parameter int TO_W    = 8,
  parameter int TIMEOUT = 200
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [DIV_W-1:0] period,
  input  logic             adc_done,
  input  logic             pid_done,
  input  logic             clr_flags,
  output logic             adc_start,
  output logic             pid_start,
  output logic             pwm_load,
  output logic             busy,
  output logic             overrun,
  output logic             timeout,
  output logic [7:0]       upd_cnt
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_SAMPLE  = 2'd1,
    ST_COMPUTE = 2'd2,
    ST_UPDATE  = 2'd3
  } state_t;

  // Last watchdog value a waiting state may reach before it is abandoned.
  localparam logic [TO_W-1:0] WD_LAST = TO_W'(TIMEOUT - 1);

  logic [DIV_W-1:0] cnt_r;
  logic [DIV_W-1:0] period_r;
  logic             tick_s;

  state_t           state_r;
  state_t           state_s;
  logic [TO_W-1:0]  wd_r;
  logic [TO_W-1:0]  wd_s;

  logic             adc_start_s;
  logic             pid_start_s;
  logic             pwm_load_s;
  logic             busy_s;
  logic             ovr_set_s;
  logic             to_set_s;
  logic             upd_inc_s;

  logic             adc_start_r;
  logic             pid_start_r;
  logic             pwm_load_r;
  logic             busy_r;
  logic             overrun_r;
  logic             timeout_r;
  logic [7:0]       upd_cnt_r;

  // The period is only sampled at a tick or while disabled, so a new value
  // never truncates or stretches the interval already running.
  assign tick_s = en && (cnt_r == period_r);

  // Prescaler: counts up to the latched period, then restarts.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_r    <= {DIV_W{1'b0}};
      period_r <= {DIV_W{1'b0}};
    end else if (!en) begin
      cnt_r    <= {DIV_W{1'b0}};
      period_r <= period;
    end else if (tick_s) begin
      cnt_r    <= {DIV_W{1'b0}};
      period_r <= period;
    end else begin
      cnt_r    <= cnt_r + 1'b1;
      period_r <= period_r;
    end
  end

  // State, watchdog and all registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= ST_IDLE;
      wd_r        <= {TO_W{1'b0}};
      adc_start_r <= 1'b0;
      pid_start_r <= 1'b0;
      pwm_load_r  <= 1'b0;
      busy_r      <= 1'b0;
      overrun_r   <= 1'b0;
      timeout_r   <= 1'b0;
      upd_cnt_r   <= 8'd0;
    end else begin
      state_r     <= state_s;
      wd_r        <= wd_s;
      adc_start_r <= adc_start_s;
      pid_start_r <= pid_start_s;
      pwm_load_r  <= pwm_load_s;
      busy_r      <= busy_s;
      // Set has priority over clear so an event is never lost.
      if (ovr_set_s) begin
        overrun_r <= 1'b1;
      end else if (clr_flags) begin
        overrun_r <= 1'b0;
      end else begin
        overrun_r <= overrun_r;
      end
      if (to_set_s) begin
        timeout_r <= 1'b1;
      end else if (clr_flags) begin
        timeout_r <= 1'b0;
      end else begin
        timeout_r <= timeout_r;
      end
      if (upd_inc_s) begin
        upd_cnt_r <= upd_cnt_r + 8'd1;
      end else begin
        upd_cnt_r <= upd_cnt_r;
      end
    end
  end

  // Next state and watchdog; a done in the expiry cycle beats the timeout.
  always_comb begin
    state_s = state_r;
    wd_s    = wd_r;
    case (state_r)
      ST_IDLE: begin
        if (tick_s) begin
          state_s = ST_SAMPLE;
          wd_s    = {TO_W{1'b0}};
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_SAMPLE: begin
        if (adc_done) begin
          state_s = ST_COMPUTE;
          wd_s    = {TO_W{1'b0}};
        end else if (wd_r == WD_LAST) begin
          state_s = ST_IDLE;
          wd_s    = {TO_W{1'b0}};
        end else begin
          wd_s    = wd_r + 1'b1;
        end
      end
      ST_COMPUTE: begin
        if (pid_done) begin
          state_s = ST_UPDATE;
          wd_s    = {TO_W{1'b0}};
        end else if (wd_r == WD_LAST) begin
          state_s = ST_IDLE;
          wd_s    = {TO_W{1'b0}};
        end else begin
          wd_s    = wd_r + 1'b1;
        end
      end
      ST_UPDATE: begin
        state_s = ST_IDLE;
      end
      default: begin
        state_s = ST_IDLE;
        wd_s    = {TO_W{1'b0}};
      end
    endcase
  end

  // Next values of the registered outputs; strobes fire on state entry.
  always_comb begin
    adc_start_s = 1'b0;
    pid_start_s = 1'b0;
    pwm_load_s  = 1'b0;
    to_set_s    = 1'b0;
    upd_inc_s   = 1'b0;
    case (state_r)
      ST_IDLE: begin
        adc_start_s = tick_s;
      end
      ST_SAMPLE: begin
        pid_start_s = adc_done;
        to_set_s    = !adc_done && (wd_r == WD_LAST);
      end
      ST_COMPUTE: begin
        pwm_load_s  = pid_done;
        to_set_s    = !pid_done && (wd_r == WD_LAST);
      end
      ST_UPDATE: begin
        upd_inc_s   = 1'b1;
      end
      default: begin
        upd_inc_s   = 1'b0;
      end
    endcase
    // A tick that finds the sequencer busy is dropped and flagged.
    ovr_set_s = tick_s && (state_r != ST_IDLE);
    busy_s    = (state_s != ST_IDLE);
  end

  assign adc_start = adc_start_r;
  assign pid_start = pid_start_r;
  assign pwm_load  = pwm_load_r;
  assign busy      = busy_r;
  assign overrun   = overrun_r;
  assign timeout   = timeout_r;
  assign upd_cnt   = upd_cnt_r;

endmodule
